// File: rtl/vc_tx_scheduler_if.sv
// Transmit-side bus of the VC scheduler: source FIFO heads and flow control
// coming in, FIFO pops and the transmitted word going out.
interface vc_tx_scheduler_if #(
    parameter int DW = 8
);
    logic [3:0]      empty;      // per-VC source FIFO empty
    logic [4*DW-1:0] data_in;    // show-ahead FIFO heads, VC i at [i*DW +: DW]
    logic [3:0]      pause;      // per-VC pause from downstream receiver
    logic [3:0]      cont;       // per-VC continue from downstream receiver
    logic [3:0]      err_in;     // per-VC overflow error from downstream
    logic [3:0]      pop;        // one-hot FIFO read, combinational
    logic            valid_out;  // data_out / vc_out valid
    logic [DW-1:0]   data_out;   // transmitted word
    logic [1:0]      vc_out;     // VC id of data_out

    // Scheduler side
    modport master (
        input  empty, data_in, pause, cont, err_in,
        output pop, valid_out, data_out, vc_out
    );

    // FIFO / link side
    modport slave (
        output empty, data_in, pause, cont, err_in,
        input  pop, valid_out, data_out, vc_out
    );
endinterface

// File: rtl/vc_tx_scheduler.sv
// Four-VC weighted round-robin transmit scheduler.
// Pops one word per cycle from the eligible VC chosen by a pointer/credit
// arbiter and presents it registered one cycle later. Downstream pause/cont
// gate individual VCs; any downstream error locks the block in ERROR.
module vc_tx_scheduler #(
    parameter int DW = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init,
    input  logic                     arb_wr,
    input  logic [1:0]               arb_sel,
    input  logic [3:0]               arb_val,
    vc_tx_scheduler_if.master        bus,
    output logic                     idle,
    output logic [3:0]               paused,
    output logic [3:0]               err_vc,
    output logic [2:0]               state_o
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q,  state_d;
    logic [3:0][3:0] weight_q, weight_d;
    logic [1:0]      ptr_q,    ptr_d;
    logic [3:0]      cnt_q,    cnt_d;
    logic [3:0]      paused_q, paused_d;
    logic [3:0]      err_vc_q, err_vc_d;
    logic            valid_q,  valid_d;
    logic [DW-1:0]   data_q,   data_d;
    logic [1:0]      vc_q,     vc_d;
    logic            idle_q,   idle_d;

    // Arbitration results
    logic [3:0]      eligible;
    logic            grant_valid;
    logic [1:0]      grant_vc;
    logic [1:0]      cand;

    // A VC may be served when it has data, is not paused (registered flag,
    // so a pause bites one cycle after it arrives) and has non-zero weight.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            eligible[i] = !bus.empty[i] && !paused_q[i] && (weight_q[i] != 4'd0);
        end
    end

    // Weighted round robin: keep serving ptr while it has credit left,
    // otherwise move to the next eligible VC in rotation. The rotation wraps
    // back to ptr itself, so a lone eligible VC restarts its credit instead
    // of stalling the link.
    always_comb begin
        // NOTE: every variable gets a default before any branch so that no
        // path leaves it unassigned; otherwise a latch would be inferred.
        grant_valid = 1'b0;
        grant_vc    = ptr_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        cand        = ptr_q;
        if (state_q == ST_ACTIVE) begin
            if (eligible[ptr_q] && (cnt_q < weight_q[ptr_q])) begin
                grant_valid = 1'b1;
                grant_vc    = ptr_q;
                cnt_d       = cnt_q + 4'd1;
            end else begin
                for (int k = 1; k <= 4; k++) begin
                    cand = ptr_q + 2'(k);
                    if (!grant_valid && eligible[cand]) begin
                        grant_valid = 1'b1;
                        grant_vc    = cand;
                        ptr_d       = cand;
                        cnt_d       = 4'd1;
                    end
                end
            end
        end
    end

    // Weights are only writable while sitting in INIT.
    always_comb begin
        weight_d = weight_q;
        if ((state_q == ST_INIT) && arb_wr) begin
            weight_d[arb_sel] = arb_val;
        end
    end

    // Per-VC pause flags and sticky error mask; frozen only in RESET.
    // A pause wins over a continue arriving in the same cycle.
    always_comb begin
        paused_d = paused_q;
        err_vc_d = err_vc_q;
        if (state_q != ST_RESET) begin
            paused_d = bus.pause | (paused_q & ~bus.cont);
            err_vc_d = err_vc_q | bus.err_in;
        end
    end

    // Next state: errors beat init, init beats the per-state rule.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET: state_d = init ? ST_INIT : ST_IDLE;
            ST_INIT, ST_IDLE, ST_ACTIVE: begin
                if (bus.err_in != 4'b0000) begin
                    state_d = ST_ERROR;
                end else if (init) begin
                    state_d = ST_INIT;
                end else begin
                    case (state_q)
                        ST_INIT:   state_d = ST_IDLE;
                        ST_IDLE:   state_d = (bus.empty != 4'b1111) ? ST_ACTIVE : ST_IDLE;
                        default:   state_d = ((bus.empty == 4'b1111) && !grant_valid)
                                             ? ST_IDLE : ST_ACTIVE;
                    endcase
                end
            end
            default:  state_d = ST_ERROR;  // ERROR is left only through rst
        endcase
    end

    // Output stage: capture the granted word; data and VC hold otherwise.
    always_comb begin
        valid_d = grant_valid;
        data_d  = data_q;
        vc_d    = vc_q;
        if (grant_valid) begin
            data_d = bus.data_in[grant_vc*DW +: DW];
            vc_d   = grant_vc;
        end
        idle_d = (state_d == ST_IDLE);
    end

    // All scheduler registers, synchronously cleared by rst.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here so every flop samples the
        // pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= ST_RESET;
            // NOTE: the weight table is a handful of flops with a defined
            // power-up value, so it is reset like the rest of the state.
            weight_q <= {4{4'd1}};
            ptr_q    <= 2'd0;
            cnt_q    <= 4'd0;
            paused_q <= 4'b0000;
            err_vc_q <= 4'b0000;
            valid_q  <= 1'b0;
            data_q   <= '0;
            vc_q     <= 2'd0;
            idle_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            weight_q <= weight_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            paused_q <= paused_d;
            err_vc_q <= err_vc_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            vc_q     <= vc_d;
            idle_q   <= idle_d;
        end
    end

    // pop drops in the same cycle rst rises so no word is lost mid-reset.
    assign bus.pop       = (grant_valid && !rst) ? (4'b0001 << grant_vc) : 4'b0000;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.vc_out    = vc_q;
    assign idle          = idle_q;
    assign paused        = paused_q;
    assign err_vc        = err_vc_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_vc_tx_scheduler.sv
// Scoreboard bench for vc_tx_scheduler: a behavioural model predicts each
// grant, pushes the expected word, and a separate monitor checks valid_out.
module tb_vc_tx_scheduler;
    localparam int DW = 8;
    localparam int S_RESET = 0, S_INIT = 1, S_IDLE = 2, S_ACTIVE = 3, S_ERROR = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       init;
    logic       arb_wr;
    logic [1:0] arb_sel;
    logic [3:0] arb_val;
    logic       idle;
    logic [3:0] paused;
    logic [3:0] err_vc;
    logic [2:0] state_o;

    vc_tx_scheduler_if #(.DW(DW)) bus ();

    vc_tx_scheduler #(.DW(DW)) dut (
        .clk     (clk),
        .rst     (rst),
        .init    (init),
        .arb_wr  (arb_wr),
        .arb_sel (arb_sel),
        .arb_val (arb_val),
        .bus     (bus),
        .idle    (idle),
        .paused  (paused),
        .err_vc  (err_vc),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    typedef struct {
        int            vc;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    // ---------------- reference model ----------------
    int          m_state = S_RESET;
    int          m_w[4]  = '{1, 1, 1, 1};
    int          m_ptr   = 0;
    int          m_cnt   = 0;
    logic [3:0]  m_paused = '0;
    logic [3:0]  m_err    = '0;
    logic [DW-1:0] m_dout = '0;
    int          m_vc    = 0;

    function automatic bit m_elig(input int v);
        return !bus.empty[v] && !m_paused[v] && (m_w[v] != 0);
    endfunction

    // VC the model grants this cycle, -1 for none.
    function automatic int m_pick();
        if (rst || m_state != S_ACTIVE) return -1;
        if (m_elig(m_ptr) && m_cnt < m_w[m_ptr]) return m_ptr;
        for (int k = 1; k <= 4; k++) begin
            if (m_elig((m_ptr + k) % 4)) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    // Advance the model across one rising edge, given this cycle's grant.
    task automatic m_clock(input int g);
        int n;
        if (rst) begin
            m_state = S_RESET; m_w = '{1, 1, 1, 1}; m_ptr = 0; m_cnt = 0;
            m_paused = '0; m_err = '0; m_dout = '0; m_vc = 0;
            return;
        end
        if (g >= 0) begin
            if (g == m_ptr && m_cnt < m_w[m_ptr]) m_cnt++;
            else begin m_ptr = g; m_cnt = 1; end
            m_dout = bus.data_in[g*DW +: DW];
            m_vc   = g;
        end
        if (m_state == S_INIT && arb_wr) m_w[arb_sel] = int'(arb_val);
        if (m_state != S_RESET) begin
            m_paused = bus.pause | (m_paused & ~bus.cont);
            m_err    = m_err | bus.err_in;
        end
        case (m_state)
            S_RESET: n = init ? S_INIT : S_IDLE;
            S_ERROR: n = S_ERROR;
            default: begin
                if (bus.err_in != 0)        n = S_ERROR;
                else if (init)              n = S_INIT;
                else if (m_state == S_INIT) n = S_IDLE;
                else if (m_state == S_IDLE) n = (bus.empty != 4'hF) ? S_ACTIVE : S_IDLE;
                else                        n = (bus.empty == 4'hF && g < 0) ? S_IDLE : S_ACTIVE;
            end
        endcase
        m_state = n;
    endtask

    // ---------------- driver ----------------
    bit recording = 0;
    int act_seq[$];

    // Inputs are set by the caller at a falling edge; one full clock follows.
    task automatic step();
        int g;
        logic [3:0] exp_pop;
        exp_t e;
        #1;
        g = m_pick();
        exp_pop = (g >= 0) ? 4'(1 << g) : 4'b0000;
        check("pop", bus.pop, exp_pop);
        if (recording) begin
            for (int i = 0; i < 4; i++) if (bus.pop[i]) act_seq.push_back(i);
        end
        if (g >= 0) begin
            e.vc = g;
            e.data = bus.data_in[g*DW +: DW];
            exp_q.push_back(e);
        end
        @(posedge clk);
        m_clock(g);
        @(negedge clk);
        check("state_o", state_o, m_state);
        check("idle", idle, (m_state == S_IDLE));
        check("paused", paused, m_paused);
        check("err_vc", err_vc, m_err);
        check("data_out_hold", bus.data_out, m_dout);
        check("vc_out_hold", bus.vc_out, m_vc);
    endtask

    task automatic quiet();
        init = 0; arb_wr = 0; arb_sel = 0; arb_val = 0;
        bus.empty = 4'hF; bus.pause = 0; bus.cont = 0; bus.err_in = 0;
    endtask

    task automatic do_reset();
        rst = 1; step(); step();
        rst = 0; step();   // RESET cycle
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (bus.valid_out === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("valid_unexpected", 32'(bus.valid_out), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("mon_vc_out", bus.vc_out, e.vc);
                    check("mon_data_out", bus.data_out, e.data);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int exp_seq[12] = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 1, 3, 3};
        quiet();
        rst = 1;
        bus.data_in = '0;
        @(negedge clk);

        // Reset, then RESET for one cycle, then IDLE with everything empty.
        do_reset();
        step(); step();

        // INIT: program weights {3,1,0,2}, then stream with all VCs full.
        init = 1; step();
        arb_wr = 1;
        arb_sel = 0; arb_val = 3; step();
        arb_sel = 1; arb_val = 1; step();
        arb_sel = 2; arb_val = 0; step();
        arb_sel = 3; arb_val = 2; step();
        arb_wr = 0; init = 0; step();
        bus.empty = 4'h0; recording = 1;
        for (int c = 0; c < 16; c++) begin
            bus.data_in = $urandom;
            // a write outside INIT must be ignored
            arb_wr = (c == 2); arb_sel = 0; arb_val = 1;
            step();
        end
        recording = 0; arb_wr = 0;
        check("wrr_seq_len", 32'(act_seq.size() >= 12), 32'd1);
        for (int i = 0; i < 12 && i < act_seq.size(); i++)
            check($sformatf("wrr_seq_%0d", i), act_seq[i], exp_seq[i]);
        // rst mid-transfer: pop must drop in the rst cycle itself
        rst = 1; step();
        quiet(); step(); rst = 0; step();

        // Default weights, only VC1 has data; pause/cont handling.
        step();
        bus.empty = 4'b1101; bus.data_in = 32'h00C3_5A00;
        repeat (3) step();
        bus.pause = 4'b0010; step();
        bus.pause = 0; repeat (3) step();
        bus.cont = 4'b0010; step();
        bus.cont = 0; repeat (2) step();
        bus.pause = 4'b0010; bus.cont = 4'b0010; step();
        bus.pause = 0; bus.cont = 0; repeat (2) step();
        bus.cont = 4'b0010; step();
        bus.cont = 0; step();

        // Single word from VC2, drain to IDLE, wake up again.
        quiet(); do_reset(); step();
        bus.data_in = 32'h00A5_0000; bus.empty = 4'b1011; step(); step();
        bus.empty = 4'hF; step(); step(); step();
        bus.empty = 4'b1110; bus.data_in = 32'h0000_0077; step(); step();
        bus.empty = 4'hF; step(); step();

        // Error from ACTIVE: lock in ERROR, init ignored, only rst exits.
        bus.empty = 4'h0; step(); step(); step();
        bus.err_in = 4'b0100; step();
        bus.err_in = 0; init = 1; repeat (3) step();
        quiet(); do_reset(); step();

        // Randomised traffic.
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) == 0) ||
                       (m_state == S_ERROR && $urandom_range(0, 9) == 0);
            init     = ($urandom_range(0, 59) == 0) ||
                       (m_state == S_INIT && $urandom_range(0, 3) != 0);
            arb_wr   = 1'($urandom_range(0, 1));
            arb_sel  = 2'($urandom);
            arb_val  = 4'($urandom);
            bus.empty   = 4'($urandom);
            bus.pause   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
            bus.cont    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            bus.err_in  = ($urandom_range(0, 499) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0000;
            bus.data_in = $urandom;
            step();
        end

        quiet(); rst = 0;
        repeat (3) step();
        check("scoreboard_leftover", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
